// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded instructions,
// resolves EX/MEM and MEM/WB forwarding, selects operands, and bubbles on load-use.

package alu_operand_stage_pkg;
  typedef enum logic [3:0] {
    addALU  = 4'd0,
    subALU  = 4'd1,
    andALU  = 4'd2,
    orALU   = 4'd3,
    xorALU  = 4'd4,
    sltALU  = 4'd5,
    sltuALU = 4'd6,
    sllALU  = 4'd7,
    srlALU  = 4'd8,
    sraALU  = 4'd9,
    luiALU  = 4'd10
  } ALU_operation_t;
endpackage

module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // decode side
  input  logic                 in_valid,
  output logic                 in_ready,
  input  ALU_operation_t       in_operation,
  input  logic [REG_IDX_W-1:0] in_rs1_idx,
  input  logic [REG_IDX_W-1:0] in_rs2_idx,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 in_use_imm,
  input  logic                 in_use_pc,
  input  logic [REG_IDX_W-1:0] in_rd_idx,
  input  logic                 in_reg_write,
  input  logic                 flush,
  // forwarding sources
  input  logic                 exm_reg_write,
  input  logic [REG_IDX_W-1:0] exm_rd_idx,
  input  logic [XLEN-1:0]      exm_data,
  input  logic                 exm_is_load,
  input  logic                 mwb_reg_write,
  input  logic [REG_IDX_W-1:0] mwb_rd_idx,
  input  logic [XLEN-1:0]      mwb_data,
  // ALU / EX-MEM side
  output ALU_operation_t       alu_operation,
  output logic [XLEN-1:0]      alu_A,
  output logic [XLEN-1:0]      alu_B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_IDX_W-1:0] out_rd_idx,
  output logic                 out_reg_write,
  output logic [XLEN-1:0]      out_pc
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready of the same interface, ready may depend
  // on valid. Upstream transfers when in_valid & in_ready, downstream when
  // out_valid & out_ready. flush overrides both for that edge.

  logic                 held_valid;
  ALU_operation_t       r_operation;
  logic [REG_IDX_W-1:0] r_rs1_idx;
  logic [REG_IDX_W-1:0] r_rs2_idx;
  logic [XLEN-1:0]      r_rs1_data;
  logic [XLEN-1:0]      r_rs2_data;
  logic [XLEN-1:0]      r_imm;
  logic [XLEN-1:0]      r_pc;
  logic                 r_use_imm;
  logic                 r_use_pc;
  logic [REG_IDX_W-1:0] r_rd_idx;
  logic                 r_reg_write;

  logic                 rs1_used;
  logic                 rs2_used;
  logic                 load_match;
  logic                 hazard;
  logic                 fire_in;
  logic                 fire_out;
  logic [XLEN-1:0]      fwd_rs1;
  logic [XLEN-1:0]      fwd_rs2;

  // Load-use: the EX/MEM load result is not available yet, so hold one cycle.
  always_comb begin
    rs1_used   = !r_use_pc;
    rs2_used   = !r_use_imm;
    load_match = exm_is_load && exm_reg_write && (exm_rd_idx != '0);
    hazard     = held_valid && load_match &&
                 ((rs1_used && (exm_rd_idx == r_rs1_idx)) ||
                  (rs2_used && (exm_rd_idx == r_rs2_idx)));
  end

  assign out_valid = held_valid && !hazard;
  assign in_ready  = !held_valid || (out_valid && out_ready);
  assign fire_in   = in_valid && in_ready;
  assign fire_out  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid  <= 1'b0;
      r_operation <= addALU;
      r_rs1_idx   <= '0;
      r_rs2_idx   <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_use_imm   <= 1'b0;
      r_use_pc    <= 1'b0;
      r_rd_idx    <= '0;
      r_reg_write <= 1'b0;
    end else if (flush) begin
      held_valid <= 1'b0;
    end else if (fire_in) begin
      held_valid  <= 1'b1;
      r_operation <= in_operation;
      r_rs1_idx   <= in_rs1_idx;
      r_rs2_idx   <= in_rs2_idx;
      r_rs1_data  <= in_rs1_data;
      r_rs2_data  <= in_rs2_data;
      r_imm       <= in_imm;
      r_pc        <= in_pc;
      r_use_imm   <= in_use_imm;
      r_use_pc    <= in_use_pc;
      r_rd_idx    <= in_rd_idx;
      r_reg_write <= in_reg_write;
    end else if (fire_out) begin
      held_valid <= 1'b0;
    end
  end

  // Younger producer (EX/MEM) wins; x0 never forwards.
  always_comb begin
    fwd_rs1 = r_rs1_data;
    if (exm_reg_write && (exm_rd_idx == r_rs1_idx) && (r_rs1_idx != '0))
      fwd_rs1 = exm_data;
    else if (mwb_reg_write && (mwb_rd_idx == r_rs1_idx) && (r_rs1_idx != '0))
      fwd_rs1 = mwb_data;
  end

  always_comb begin
    fwd_rs2 = r_rs2_data;
    if (exm_reg_write && (exm_rd_idx == r_rs2_idx) && (r_rs2_idx != '0))
      fwd_rs2 = exm_data;
    else if (mwb_reg_write && (mwb_rd_idx == r_rs2_idx) && (r_rs2_idx != '0))
      fwd_rs2 = mwb_data;
  end

  assign alu_operation = r_operation;
  assign alu_A         = r_use_pc  ? r_pc  : fwd_rs1;
  assign alu_B         = r_use_imm ? r_imm : fwd_rs2;
  assign out_rd_idx    = r_rd_idx;
  assign out_reg_write = r_reg_write && out_valid;
  assign out_pc        = r_pc;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding priority, x0 guard, load-use,
// backpressure, flush, immediate/PC select and asynchronous reset.

module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  ALU_operation_t       in_operation;
  logic [REG_IDX_W-1:0] in_rs1_idx;
  logic [REG_IDX_W-1:0] in_rs2_idx;
  logic [XLEN-1:0]      in_rs1_data;
  logic [XLEN-1:0]      in_rs2_data;
  logic [XLEN-1:0]      in_imm;
  logic [XLEN-1:0]      in_pc;
  logic                 in_use_imm;
  logic                 in_use_pc;
  logic [REG_IDX_W-1:0] in_rd_idx;
  logic                 in_reg_write;
  logic                 flush;
  logic                 exm_reg_write;
  logic [REG_IDX_W-1:0] exm_rd_idx;
  logic [XLEN-1:0]      exm_data;
  logic                 exm_is_load;
  logic                 mwb_reg_write;
  logic [REG_IDX_W-1:0] mwb_rd_idx;
  logic [XLEN-1:0]      mwb_data;
  ALU_operation_t       alu_operation;
  logic [XLEN-1:0]      alu_A;
  logic [XLEN-1:0]      alu_B;
  logic                 out_valid;
  logic                 out_ready;
  logic [REG_IDX_W-1:0] out_rd_idx;
  logic                 out_reg_write;
  logic [XLEN-1:0]      out_pc;

  int n_checks;
  int n_fails;

  alu_operand_stage #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_operation(in_operation),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
    .in_rd_idx(in_rd_idx), .in_reg_write(in_reg_write), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd_idx(exm_rd_idx), .exm_data(exm_data),
    .exm_is_load(exm_is_load),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_idx(mwb_rd_idx), .mwb_data(mwb_data),
    .alu_operation(alu_operation), .alu_A(alu_A), .alu_B(alu_B),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_idx(out_rd_idx),
    .out_reg_write(out_reg_write), .out_pc(out_pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input ALU_operation_t op,
                       input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [4:0] rd, input logic [31:0] pc);
    in_valid     = 1'b1;
    in_operation = op;
    in_rs1_idx   = rs1;
    in_rs1_data  = d1;
    in_rs2_idx   = rs2;
    in_rs2_data  = d2;
    in_rd_idx    = rd;
    in_pc        = pc;
    in_reg_write = 1'b1;
    in_use_imm   = 1'b0;
    in_use_pc    = 1'b0;
    in_imm       = '0;
  endtask

  task automatic clear_fwd();
    exm_reg_write = 1'b0; exm_rd_idx = '0; exm_data = '0; exm_is_load = 1'b0;
    mwb_reg_write = 1'b0; mwb_rd_idx = '0; mwb_data = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    offer(addALU, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    in_valid = 1'b0; in_reg_write = 1'b0;
    clear_fwd();

    // reset state
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_alu_op", alu_operation, addALU);
    check("rst_alu_A", alu_A, 32'd0);
    check("rst_alu_B", alu_B, 32'd0);
    check("rst_out_reg_write", out_reg_write, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1'b1);

    // 1. forwarding priority on rs1
    out_ready = 1'b0;
    offer(addALU, 5'd5, 32'd11, 5'd6, 32'd22, 5'd7, 32'h10);
    tick();
    in_valid = 1'b0;
    exm_reg_write = 1'b1; exm_rd_idx = 5'd5; exm_data = 32'd100;
    mwb_reg_write = 1'b1; mwb_rd_idx = 5'd5; mwb_data = 32'd7;
    #1;
    check("fwd_exm_A", alu_A, 32'd100);
    check("fwd_B_regfile", alu_B, 32'd22);
    check("fwd_out_valid", out_valid, 1'b1);
    check("fwd_out_rd", out_rd_idx, 5'd7);
    check("fwd_out_reg_write", out_reg_write, 1'b1);
    check("fwd_in_ready_stalled", in_ready, 1'b0);
    exm_reg_write = 1'b0; #1;
    check("fwd_mwb_A", alu_A, 32'd7);
    mwb_reg_write = 1'b0; #1;
    check("fwd_none_A", alu_A, 32'd11);
    out_ready = 1'b1;
    tick();
    check("fwd_fired", out_valid, 1'b0);

    // 2. x0 guard
    out_ready = 1'b0;
    offer(addALU, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'h20);
    tick();
    in_valid = 1'b0;
    exm_reg_write = 1'b1; exm_rd_idx = 5'd0; exm_data = 32'd55;
    mwb_reg_write = 1'b1; mwb_rd_idx = 5'd0; mwb_data = 32'd66;
    #1;
    check("x0_A", alu_A, 32'd0);
    check("x0_B", alu_B, 32'd0);
    clear_fwd();
    out_ready = 1'b1;
    tick();
    check("x0_fired_in_ready", in_ready, 1'b1);

    // 3. load-use on rs2
    offer(subALU, 5'd1, 32'd40, 5'd3, 32'd2, 5'd4, 32'h30);
    tick();
    in_valid = 1'b0;
    exm_is_load = 1'b1; exm_reg_write = 1'b1; exm_rd_idx = 5'd3; exm_data = 32'hBAD;
    #1;
    check("lu_out_valid", out_valid, 1'b0);
    check("lu_in_ready", in_ready, 1'b0);
    check("lu_out_reg_write", out_reg_write, 1'b0);
    check("lu_alu_op", alu_operation, subALU);
    tick();
    check("lu_still_held", out_valid, 1'b0);
    clear_fwd();
    mwb_reg_write = 1'b1; mwb_rd_idx = 5'd3; mwb_data = 32'd9;
    #1;
    check("lu_release_valid", out_valid, 1'b1);
    check("lu_release_B", alu_B, 32'd9);
    check("lu_release_A", alu_A, 32'd40);
    tick();
    check("lu_fired", out_valid, 1'b0);
    clear_fwd();

    // load on a register the instruction does not read (rs2 replaced by imm): no bubble
    offer(addALU, 5'd1, 32'd5, 5'd3, 32'd0, 5'd4, 32'h34);
    in_use_imm = 1'b1; in_imm = 32'd8;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    exm_is_load = 1'b1; exm_reg_write = 1'b1; exm_rd_idx = 5'd3;
    #1;
    check("lu_unused_rs2_valid", out_valid, 1'b1);
    check("lu_unused_rs2_B", alu_B, 32'd8);
    clear_fwd();
    out_ready = 1'b1;
    tick();

    // 4. backpressure with a second instruction waiting
    out_ready = 1'b0;
    offer(addALU, 5'd2, 32'h22, 5'd0, 32'd0, 5'd9, 32'h40);
    tick();
    offer(xorALU, 5'd2, 32'h33, 5'd0, 32'd0, 5'd10, 32'h80);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_rd_held", out_rd_idx, 5'd9);
      check("bp_pc_held", out_pc, 32'h40);
      check("bp_A_held", alu_A, 32'h22);
      tick();
    end
    out_ready = 1'b1; #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; #1;
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_rd", out_rd_idx, 5'd10);
    check("bp_next_pc", out_pc, 32'h80);
    check("bp_next_op", alu_operation, xorALU);
    tick();
    check("bp_next_fired", out_valid, 1'b0);

    // 5. flush kills held and offered instructions
    out_ready = 1'b0;
    offer(orALU, 5'd1, 32'd1, 5'd2, 32'd2, 5'd12, 32'h90);
    tick();
    offer(andALU, 5'd1, 32'd1, 5'd2, 32'd2, 5'd13, 32'hA0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_not_captured_rd", out_rd_idx, 5'd12);
    check("flush_in_ready", in_ready, 1'b1);
    tick();
    check("flush_stays_empty", out_valid, 1'b0);

    // 6. immediate / PC select, then reset while holding
    offer(addALU, 5'd5, 32'd1, 5'd6, 32'd2, 5'd8, 32'h100);
    in_use_pc = 1'b1; in_use_imm = 1'b1; in_imm = 32'hFFFF_FFFC;
    tick();
    in_valid = 1'b0;
    exm_is_load = 1'b1; exm_reg_write = 1'b1; exm_rd_idx = 5'd5; exm_data = 32'hDEAD;
    #1;
    check("imm_A_pc", alu_A, 32'h100);
    check("imm_B_imm", alu_B, 32'hFFFF_FFFC);
    check("imm_op", alu_operation, addALU);
    check("imm_no_hazard", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_pc", out_pc, 32'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    clear_fwd();
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
